pixel_ram_arbiter: RTL and testbench

- Shares one single-port pixel RAM between two requesters: the capture-side writer (HDMI pixel ingest) and the LED-side reader (APA102 streamer).
- Grants at most one RAM access per clock. Arbitration is round-robin on contention, with valid/ready handshakes on both sides.
- Contains a clear engine that zero-fills the whole RAM on command, with priority over both requesters.
- Instantiates the RAM internally and is the only block that drives its address, write-data and write-enable inputs.

---
 rtl/pixel_ram_pkg.sv | 17 +
 rtl/simple_ram.sv | 23 ++
 rtl/pixel_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_pixel_ram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ram_pkg.sv
// Shared types and default geometry for the pixel RAM, its arbiter, and the capture/streamer blocks.
package pixel_ram_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } grant_e;

  localparam int DEFAULT_WIDTH = 24;
  localparam int DEFAULT_DEPTH = 256;

endpackage

// File: rtl/simple_ram.sv
// Single-port RAM with registered read data (read-before-write) and no reset.
// Latency: read data valid 1 cycle after the address is presented; no backpressure.
module simple_ram #(
  parameter int SIZE  = 24,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic                     we_i,
  input  logic [SIZE-1:0]          wdata_i,
  output logic [SIZE-1:0]          rdata_o
);

  logic [SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/pixel_ram_arbiter.sv
// Round-robin arbiter sharing one pixel RAM between writer and reader, plus a zero-fill clear engine.
// Read response 1 cycle after grant; ready is combinational from valid; clear blocks both requesters.
module pixel_ram_arbiter
  import pixel_ram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     rd_resp_valid,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_e         state_q, state_d;
  grant_e         last_grant_q, last_grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           rd_resp_valid_q;

  logic           wr_gnt, rd_gnt;
  logic           ram_we;
  logic [WIDTH-1:0] ram_wdata;
  logic           done;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_gnt       = 1'b0;
    rd_gnt       = 1'b0;
    ram_we       = 1'b0;
    ram_wdata    = wr_data;
    done         = 1'b0;

    case (state_q)
      ARB: begin
        // Gating with rst_n keeps ready low and the RAM untouched while reset is held.
        if (rst_n) begin
          if (wr_valid && rd_valid) begin
            wr_gnt = (last_grant_q == RD);
            rd_gnt = (last_grant_q == WR);
          end else begin
            wr_gnt = wr_valid;
            rd_gnt = rd_valid;
          end
        end
        if (wr_gnt) begin
          addr_d       = wr_addr;
          ram_we       = 1'b1;
          last_grant_d = WR;
        end else if (rd_gnt) begin
          addr_d       = rd_addr;
          last_grant_d = RD;
        end
        if (clear_start) begin
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        addr_d    = cnt_q[AW-1:0];
        ram_we    = 1'b1;
        ram_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = ARB;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ARB;
      last_grant_q    <= WR;
      cnt_q           <= '0;
      addr_q          <= '0;
      rd_resp_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      rd_resp_valid_q <= rd_gnt;
    end
  end

  simple_ram #(
    .SIZE  (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .addr_i  (addr_d),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (rd_data)
  );

  assign wr_ready      = wr_gnt;
  assign rd_ready      = rd_gnt;
  assign rd_resp_valid = rd_resp_valid_q;
  assign clear_busy    = (state_q == CLEAR);
  assign clear_done    = done;

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Self-checking bench for pixel_ram_arbiter: directed vector table, clear/reset sequences,
// and randomized traffic compared against a transaction-level memory model.
module tb_pixel_ram_arbiter;

  localparam int WIDTH = 24;
  localparam int DEPTH = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid, wr_ready;
  logic [7:0]        wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_valid, rd_ready;
  logic [7:0]        rd_addr;
  logic              rd_resp_valid;
  logic [WIDTH-1:0]  rd_data;
  logic              clear_start, clear_busy, clear_done;

  pixel_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_data       (rd_data),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, who was served most recently, outstanding response, clear progress.
  logic [WIDTH-1:0] m_mem   [DEPTH];
  bit               m_known [DEPTH];
  bit               m_last_rd;
  int               m_clear_left;
  bit               m_pend;
  bit               m_pknown;
  logic [WIDTH-1:0] m_pdata;

  logic obs_wr, obs_rd, obs_rsp, obs_busy, obs_done;
  logic [WIDTH-1:0] obs_data;

  task automatic model_reset(input bit forget_mem);
    m_last_rd    = 1'b0;
    m_clear_left = 0;
    m_pend       = 1'b0;
    m_pknown     = 1'b0;
    m_pdata      = '0;
    if (forget_mem)
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, compare, advance the model.
  task automatic cyc(input logic wv, input logic [7:0] wa, input logic [WIDTH-1:0] wd,
                     input logic rv, input logic [7:0] ra, input logic cs);
    bit e_wr, e_rd, e_busy, e_done;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; clear_start = cs;
    #1;
    obs_wr = wr_ready; obs_rd = rd_ready; obs_rsp = rd_resp_valid;
    obs_busy = clear_busy; obs_done = clear_done; obs_data = rd_data;

    e_busy = (m_clear_left > 0);
    e_done = (m_clear_left == 1);
    if (e_busy) begin
      e_wr = 1'b0; e_rd = 1'b0;
    end else if (wv && rv) begin
      e_rd = !m_last_rd; e_wr = m_last_rd;
    end else begin
      e_wr = wv; e_rd = rv;
    end

    check("m_wr_ready", obs_wr, e_wr);
    check("m_rd_ready", obs_rd, e_rd);
    check("m_resp_valid", obs_rsp, m_pend);
    check("m_clear_busy", obs_busy, e_busy);
    check("m_clear_done", obs_done, e_done);
    if (m_pend && m_pknown) check("m_rd_data", obs_data, m_pdata);

    m_pend = e_rd;
    if (e_rd) begin
      m_pknown = m_known[ra];
      m_pdata  = m_mem[ra];
    end
    if (e_wr) begin
      m_mem[wa] = wd; m_known[wa] = 1'b1;
    end
    if (e_wr || e_rd) m_last_rd = e_rd;
    if (e_busy) begin
      m_mem[DEPTH - m_clear_left]   = '0;
      m_known[DEPTH - m_clear_left] = 1'b1;
      m_clear_left--;
    end else if (cs) begin
      m_clear_left = DEPTH;
    end
    @(negedge clk);
  endtask

  // Clear run with valids held; optionally re-pulse mid-clear and/or start it alongside a read grant.
  task automatic run_clear(input bit restart_mid, input bit with_read, input logic [WIDTH-1:0] rd_exp);
    int busy_len = 0;
    int done_cnt = 0;
    cyc(1'b0, 8'd0, '0, with_read, 8'd128, 1'b1);
    if (with_read) check("clr_coinc_rd_ready", obs_rd, 1'b1);
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 8'd3, 24'hFFFFFF, 1'b1, 8'd7, (restart_mid && i == 50));
      if (obs_busy) begin
        busy_len++;
        check("clr_no_wr_ready", obs_wr, 1'b0);
        check("clr_no_rd_ready", obs_rd, 1'b0);
      end
      if (obs_done) done_cnt++;
      if (i == 0 && with_read) begin
        check("clr_coinc_resp", obs_rsp, 1'b1);
        check("clr_coinc_data", obs_data, rd_exp);
      end
      if (!obs_busy) break;
    end
    check("clr_busy_len", busy_len, DEPTH);
    check("clr_done_cnt", done_cnt, 1);
  endtask

  typedef struct {
    logic             wv;
    logic [7:0]       wa;
    logic [WIDTH-1:0] wd;
    logic             rv;
    logic [7:0]       ra;
    logic             ewr;
    logic             erd;
    logic             ersp;
    logic             chk;
    logic [WIDTH-1:0] edat;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int done_cnt;

    // Contention from reset alternates starting with the reader.
    tbl[0]  = '{1'b1, 8'd9, 24'h123456, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[1]  = '{1'b1, 8'd9, 24'h123456, 1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0};
    tbl[2]  = '{1'b1, 8'd9, 24'h123456, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[3]  = '{1'b1, 8'd9, 24'h123456, 1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 1'b1, 24'h123456};
    tbl[4]  = '{1'b1, 8'd9, 24'h123456, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[5]  = '{1'b1, 8'd9, 24'h123456, 1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 1'b1, 24'h123456};
    tbl[6]  = '{1'b1, 8'd5, 24'hABCDEF, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[7]  = '{1'b0, 8'd0, 24'h0,      1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[8]  = '{1'b0, 8'd0, 24'h0,      1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'hABCDEF};
    tbl[9]  = '{1'b1, 8'd0, 24'h000011, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[10] = '{1'b1, 8'd1, 24'h000022, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[11] = '{1'b1, 8'd2, 24'h000033, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[12] = '{1'b0, 8'd0, 24'h0,      1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[13] = '{1'b0, 8'd0, 24'h0,      1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000011};
    tbl[14] = '{1'b0, 8'd0, 24'h0,      1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000022};
    tbl[15] = '{1'b0, 8'd0, 24'h0,      1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000033};

    // Reset held with both valids asserted: nothing may be granted.
    rst_n = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = '0; rd_addr = '0;
    wr_data = '0; clear_start = 1'b0;
    model_reset(1'b1);
    @(negedge clk); @(negedge clk); #1;
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_ready", rd_ready, 1'b0);
    check("rst_resp_valid", rd_resp_valid, 1'b0);
    check("rst_clear_busy", clear_busy, 1'b0);
    check("rst_clear_done", clear_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, 1'b0);
      check($sformatf("vec%0d_wr_ready", i), obs_wr, tbl[i].ewr);
      check($sformatf("vec%0d_rd_ready", i), obs_rd, tbl[i].erd);
      check($sformatf("vec%0d_resp_valid", i), obs_rsp, tbl[i].ersp);
      check($sformatf("vec%0d_both_ready", i), obs_wr & obs_rd, 1'b0);
      if (tbl[i].chk) check($sformatf("vec%0d_rd_data", i), obs_data, tbl[i].edat);
    end

    // Fill everything, clear, and confirm zeros at both ends and the middle.
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, 8'(a), 24'hFFFFFF, 1'b0, 8'd0, 1'b0);
    run_clear(1'b0, 1'b0, '0);
    cyc(1'b0, 8'd0, '0, 1'b1, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, '0, 1'b1, 8'd128, 1'b0);
    check("clr_rd0_valid", obs_rsp, 1'b1);
    check("clr_rd0_data", obs_data, 24'h0);
    cyc(1'b0, 8'd0, '0, 1'b1, 8'd255, 1'b0);
    check("clr_rd128_valid", obs_rsp, 1'b1);
    check("clr_rd128_data", obs_data, 24'h0);
    cyc(1'b0, 8'd0, '0, 1'b0, 8'd0, 1'b0);
    check("clr_rd255_valid", obs_rsp, 1'b1);
    check("clr_rd255_data", obs_data, 24'h0);

    // Clear started alongside a read grant, with a second start pulse mid-clear.
    cyc(1'b1, 8'd128, 24'h5A5A5A, 1'b0, 8'd0, 1'b0);
    run_clear(1'b1, 1'b1, 24'h5A5A5A);

    // Reset 100 cycles into a clear.
    done_cnt = 0;
    cyc(1'b0, 8'd0, '0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 8'd4, 24'h777777, 1'b1, 8'd4, 1'b0);
      if (obs_done) done_cnt++;
    end
    check("rstclr_no_done", done_cnt, 0);
    rst_n = 1'b0;
    #1;
    check("rstclr_busy", clear_busy, 1'b0);
    check("rstclr_resp_valid", rd_resp_valid, 1'b0);
    check("rstclr_wr_ready", wr_ready, 1'b0);
    check("rstclr_rd_ready", rd_ready, 1'b0);
    check("rstclr_done", clear_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(1'b1);
    cyc(1'b1, 8'd4, 24'h777777, 1'b1, 8'd4, 1'b0);
    check("rstclr_first_rd", obs_rd, 1'b1);
    check("rstclr_first_wr", obs_wr, 1'b0);

    // Randomized traffic on a small address window for frequent read-after-write hits.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 24'($urandom),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
          ($urandom_range(0, 399) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
